// File: rtl/stream_dist8_pkg.sv
// stream_dist8 shared definitions: lane count, select width, default word
// width and the small decode/select helpers used by the top level.
package stream_dist8_pkg;

  localparam int DIST_LANES = 8;
  localparam int DIST_SEL_W = 3;
  localparam int DIST_WIDTH = 16;

  typedef logic [DIST_SEL_W-1:0] lane_sel_t;
  typedef logic [DIST_LANES-1:0] lane_vec_t;

  // One-hot demultiplex of a single bit onto the selected lane.
  function automatic lane_vec_t dmux8(input logic i_bit, input lane_sel_t i_sel);
    lane_vec_t r_vec;
    r_vec        = '0;
    r_vec[i_sel] = i_bit;
    return r_vec;
  endfunction

  // 8-way 1-bit select.
  function automatic logic sel8(input lane_vec_t i_vec, input lane_sel_t i_sel);
    return i_vec[i_sel];
  endfunction

endpackage

// File: rtl/stream_dist8_if.sv
// Bundle of the producer-side stream, the eight consumer lanes and the
// status outputs of the distributor. master = producer/consumers, slave = DUT.
interface stream_dist8_if
  import stream_dist8_pkg::*;
#(
  parameter int WIDTH = DIST_WIDTH
) ();

  logic                        in_valid;
  logic                        in_ready;
  logic [WIDTH-1:0]            in_data;
  logic [DIST_SEL_W-1:0]       in_sel;
  logic                        rr_mode;
  logic [DIST_LANES-1:0]       out_valid;
  logic [DIST_LANES-1:0]       out_ready;
  logic [DIST_LANES*WIDTH-1:0] out_data;
  logic [DIST_SEL_W-1:0]       rr_ptr;
  logic                        busy;

  modport master (
    output in_valid, in_data, in_sel, rr_mode, out_ready,
    input  in_ready, out_valid, out_data, rr_ptr, busy
  );

  modport slave (
    input  in_valid, in_data, in_sel, rr_mode, out_ready,
    output in_ready, out_valid, out_data, rr_ptr, busy
  );

endinterface

// File: rtl/stream_dist8_lane.sv
// One-entry holding slot for a single output lane. A load in the same cycle
// as a drain wins, so a lane can sustain one word per cycle with no bubble.
module stream_dist8_lane #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_drain,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Slot state: load has priority over drain; data is kept after a drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_load_data;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/stream_dist8.sv
// One-to-eight word distributor. Each accepted word goes to the lane chosen
// by in_sel or, in round-robin mode, by an internal pointer that advances
// only on accepted words, so a blocked lane stalls the producer in order.
module stream_dist8
  import stream_dist8_pkg::*;
#(
  parameter int WIDTH = DIST_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  stream_dist8_if.slave bus
);

  logic [DIST_SEL_W-1:0] r_rr_ptr;
  lane_sel_t             w_dest;
  lane_vec_t             w_valid;
  lane_vec_t             w_open;
  lane_vec_t             w_load;
  lane_vec_t             w_drain;
  logic                  w_in_ready;
  logic                  w_accept;

  // in_sel is ignored entirely in round-robin mode, including for ready.
  assign w_dest     = bus.rr_mode ? r_rr_ptr : bus.in_sel;
  assign w_open     = ~w_valid | bus.out_ready;
  assign w_in_ready = ~reset & sel8(w_open, w_dest);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_load     = dmux8(w_accept, w_dest);
  assign w_drain    = w_valid & bus.out_ready;

  for (genvar gi = 0; gi < DIST_LANES; gi++) begin : g_lane
    stream_dist8_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load[gi]),
      .i_load_data(bus.in_data),
      .i_drain    (w_drain[gi]),
      .o_valid    (w_valid[gi]),
      .o_data     (bus.out_data[gi*WIDTH +: WIDTH])
    );
  end

  // Round-robin pointer: advances only when a word is taken in rr mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_accept & bus.rr_mode) begin
      r_rr_ptr <= r_rr_ptr + 3'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;
  assign bus.rr_ptr    = r_rr_ptr;
  assign bus.busy      = |w_valid;

endmodule

// File: tb/tb_stream_dist8.sv
// Directed bench for stream_dist8 with a per-lane scoreboard: words are
// pushed when the bench sees an accept and retired when the lane drains.
module tb_stream_dist8;

  typedef logic [15:0] wq_t[$];

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  wq_t        q[8];
  logic [2:0] m_ptr;

  stream_dist8_if #(.WIDTH(16)) bus ();

  stream_dist8 #(.WIDTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lane(input int i);
    return bus.out_data[i*16 +: 16];
  endfunction

  task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] s,
                       input logic rr, input logic [7:0] ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_sel    = s;
    bus.rr_mode   = rr;
    bus.out_ready = ordy;
  endtask

  // Compare DUT against the scoreboard, then apply this cycle's handshakes.
  task automatic sb_cycle();
    logic [7:0] ev;
    logic [2:0] d;
    logic       rdy;
    for (int i = 0; i < 8; i++) ev[i] = (q[i].size() != 0);
    chk("sb_out_valid", 32'(bus.out_valid), 32'(ev));
    chk("sb_busy", 32'(bus.busy), 32'(|ev));
    chk("sb_rr_ptr", 32'(bus.rr_ptr), 32'(m_ptr));
    for (int i = 0; i < 8; i++)
      if (ev[i]) chk("sb_lane_data", 32'(lane(i)), 32'(q[i][0]));
    d   = bus.rr_mode ? m_ptr : bus.in_sel;
    rdy = !reset && (!ev[d] || bus.out_ready[d]);
    chk("sb_in_ready", 32'(bus.in_ready), 32'(rdy));
    if (reset) begin
      for (int i = 0; i < 8; i++) q[i].delete();
      m_ptr = 3'd0;
    end else begin
      for (int i = 0; i < 8; i++)
        if (ev[i] && bus.out_ready[i]) void'(q[i].pop_front());
      if (bus.in_valid && rdy) begin
        q[d].push_back(bus.in_data);
        if (bus.rr_mode) m_ptr = m_ptr + 3'd1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sb_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_ptr = 3'd0;
    reset = 1'b1;
    drive(1'b1, 16'h1234, 3'd0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    for (int i = 0; i < 8; i++) chk("rst_out_data", 32'(lane(i)), 32'h0);
    chk("rst_rr_ptr", 32'(bus.rr_ptr), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    step();
    reset = 1'b0;
    drive(1'b0, 16'h0, 3'd0, 1'b0, 8'h00);

    // Explicit select, one word to lane 5, stalled consumer.
    drive(1'b1, 16'hBEEF, 3'd5, 1'b0, 8'h00);
    #1 chk("t1_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    chk("t1_out_valid", 32'(bus.out_valid), 32'h20);
    chk("t1_lane5", 32'(lane(5)), 32'hBEEF);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    drive(1'b1, 16'hCAFE, 3'd5, 1'b0, 8'h00);
    #1 chk("t1_sel5_blocked", 32'(bus.in_ready), 32'h0);
    bus.in_sel = 3'd2;
    #1 chk("t1_sel2_ready", 32'(bus.in_ready), 32'h1);
    step();
    chk("t1_lane2", 32'(lane(2)), 32'hCAFE);
    drive(1'b0, 16'h0, 3'd0, 1'b0, 8'hFF);
    step();

    // Round-robin, ten back-to-back words with all consumers ready.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 16'(k), 3'd6, 1'b1, 8'hFF);
      #1 chk("t2_in_ready", 32'(bus.in_ready), 32'h1);
      step();
    end
    drive(1'b0, 16'h0, 3'd0, 1'b1, 8'hFF);
    chk("t2_rr_ptr", 32'(bus.rr_ptr), 32'h2);
    chk("t2_lane0_word8", 32'(lane(0)), 32'h8);
    chk("t2_lane1_word9", 32'(lane(1)), 32'h9);
    chk("t2_lane7_word7", 32'(lane(7)), 32'h7);
    step();

    // Strict-order blocking on a full lane 3 at rr_ptr=3.
    drive(1'b1, 16'h0033, 3'd3, 1'b0, 8'h00);
    step();
    drive(1'b1, 16'h0022, 3'd5, 1'b1, 8'h00);
    step();
    chk("t3_ptr_at_3", 32'(bus.rr_ptr), 32'h3);
    drive(1'b1, 16'h0044, 3'd5, 1'b1, 8'h00);
    #1 chk("t3_blocked", 32'(bus.in_ready), 32'h0);
    step();
    chk("t3_ptr_held", 32'(bus.rr_ptr), 32'h3);
    chk("t3_lane3_old", 32'(lane(3)), 32'h33);
    bus.out_ready = 8'h08;
    #1 chk("t3_unblocked", 32'(bus.in_ready), 32'h1);
    step();
    chk("t3_lane3_valid", 32'(bus.out_valid[3]), 32'h1);
    chk("t3_lane3_new", 32'(lane(3)), 32'h44);
    chk("t3_ptr_4", 32'(bus.rr_ptr), 32'h4);
    drive(1'b0, 16'h0, 3'd0, 1'b0, 8'hFF);
    step();

    // Simultaneous drain and load on lane 0, four cycles.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 16'(k), 3'd0, 1'b0, 8'h01);
      #1 chk("t4_in_ready", 32'(bus.in_ready), 32'h1);
      step();
      chk("t4_lane0_valid", 32'(bus.out_valid[0]), 32'h1);
      chk("t4_lane0_data", 32'(lane(0)), 32'(k));
    end
    drive(1'b0, 16'h0, 3'd0, 1'b0, 8'hFF);
    step();

    // Fill lanes 0,4,7 then reset mid-transfer with a word offered.
    drive(1'b1, 16'h00A0, 3'd0, 1'b0, 8'h00);
    step();
    drive(1'b1, 16'h00A4, 3'd4, 1'b0, 8'h00);
    step();
    drive(1'b1, 16'h00A7, 3'd7, 1'b0, 8'h00);
    step();
    chk("t5_filled", 32'(bus.out_valid), 32'h91);
    reset = 1'b1;
    drive(1'b1, 16'hDEAD, 3'd1, 1'b0, 8'h00);
    #1 chk("t5_rst_in_ready", 32'(bus.in_ready), 32'h0);
    step();
    reset = 1'b0;
    drive(1'b0, 16'h0, 3'd0, 1'b0, 8'h00);
    chk("t5_out_valid", 32'(bus.out_valid), 32'h0);
    chk("t5_rr_ptr", 32'(bus.rr_ptr), 32'h0);
    chk("t5_lane1_not_captured", 32'(lane(1)), 32'h0);
    chk("t5_lane0_cleared", 32'(lane(0)), 32'h0);
    chk("t5_busy", 32'(bus.busy), 32'h0);

    // Pointer holds across a switch to explicit mode and back.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 16'(16'h60 + k), 3'd0, 1'b1, 8'hFF);
      step();
    end
    chk("t6_ptr_6", 32'(bus.rr_ptr), 32'h6);
    drive(1'b1, 16'h0071, 3'd1, 1'b0, 8'hFF);
    step();
    drive(1'b1, 16'h0072, 3'd1, 1'b0, 8'hFF);
    step();
    chk("t6_ptr_held", 32'(bus.rr_ptr), 32'h6);
    chk("t6_lane1", 32'(lane(1)), 32'h72);
    drive(1'b1, 16'h0066, 3'd1, 1'b1, 8'hFF);
    #1 chk("t6_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    chk("t6_out_valid", 32'(bus.out_valid), 32'h40);
    chk("t6_lane6", 32'(lane(6)), 32'h66);
    chk("t6_ptr_7", 32'(bus.rr_ptr), 32'h7);
    drive(1'b0, 16'h0, 3'd0, 1'b0, 8'hFF);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_dist8.md
Name: stream_dist8

Overview:
- One-to-eight word distributor: the inverse of the 8-way 16-bit selector. It routes one input stream of 16-bit words to eight output lanes.
- Each lane has a one-entry holding register with valid/ready handshake, so a stalled lane does not corrupt others.
- Destination comes from an explicit lane address or an internal round-robin pointer.
- Sits between a single producer (CPU output port / memory-mapped write path) and eight consumer peripherals.

Parameters:
- WIDTH, 16, data word width per lane; lane count is fixed at 8.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word this cycle.
- in_ready  output  1  distributor accepts the word this cycle.
- in_data  input  WIDTH  word to distribute.
- in_sel  input  3  destination lane; used only when rr_mode=0.
- rr_mode  input  1  1 = ignore in_sel and use the round-robin pointer.
- out_valid  output  8  bit i: lane i holds a word.
- out_ready  input  8  bit i: consumer i takes the word this cycle.
- out_data  output  8*WIDTH  lane i data on bits [i*WIDTH +: WIDTH].
- rr_ptr  output  3  current round-robin pointer.
- busy  output  1  OR of out_valid.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset (sync, active-high): out_valid=0, all out_data=0, rr_ptr=0, busy=0. in_ready is 0 during reset regardless of inputs.
- Reset asserted mid-transfer: pending lane words are discarded, nothing is accepted in that cycle, and the pointer returns to 0.
- Destination: dest = rr_mode ? rr_ptr : in_sel. This is combinational, so a change to rr_mode or in_sel takes effect in the same cycle.
- Ready: in_ready = ~out_valid[dest] | out_ready[dest]. This is a combinational path from out_ready to in_ready and is permitted.
- Accept: accept = in_valid & in_ready. On accept:
  - lane[dest] data <= in_data;
  - out_valid[dest] <= 1.
- Latency: exactly 1 cycle from accept to out_valid.
- Drain: when out_valid[i] & out_ready[i] and lane i is not loaded in the same cycle, out_valid[i] <= 0. out_data[i] holds its last value; it is not cleared.
- Simultaneous drain and load on the same lane: the new word replaces the old one, out_valid stays 1, and no bubble is inserted. Full throughput is 1 word/cycle per lane.
- Lanes other than dest are unaffected by an accept. Drains on all 8 lanes may occur in the same cycle.
- Output stability: while out_valid[i]=1 and out_ready[i]=0, out_data[i] stays stable.
- Round-robin pointer:
  - increments by 1 only on accept with rr_mode=1;
  - wraps 7 -> 0;
  - holds when rr_mode=0 and holds across mode changes.
- Blocked lane: if the pointed-to lane is full and not ready, in_ready=0 and the pointer does not skip ahead (strict order).
- in_sel with rr_mode=1 is ignored entirely, including in the ready computation.
- in_valid=0: no state change except drains.
- busy = |out_valid, derived from registered state.

Decomposition:
- Shared include dist_defs.v holds:
  - DIST_LANES=8;
  - DIST_SEL_W=3;
  - the default WIDTH.
- Sub-module dist_lane: a one-entry register slot.
  - Inputs: clk, reset, load, load_data, drain.
  - Outputs: valid, data.
  - Instantiated 8 times.
- Top-level logic:
  - load strobes come from DMux8Way driven by accept and dest;
  - ready selection is an 8-way 1-bit select of (~valid | out_ready) by dest;
  - rr_ptr is a 3-bit incrementer register.

Test Plan:
- Reset, then rr_mode=0, in_sel=5, in_data=16'hBEEF, in_valid=1 for 1 cycle, out_ready=0 -> out_valid=8'b0010_0000 next cycle, lane5 data=BEEF, busy=1. A second word to sel=5 sees in_ready=0; the same word to sel=2 sees in_ready=1.
- rr_mode=1, out_ready=8'hFF, push 10 words 0..9 back-to-back -> in_ready=1 every cycle. Lanes receive in order 0..7,0,1 (word 8 to lane 0, word 9 to lane 1). rr_ptr reads 2 afterward.
- rr_mode=1, out_ready[3]=0, lane3 full, rr_ptr=3 -> in_ready=0 and rr_ptr held at 3. Raising out_ready[3] for one cycle with in_valid=1 -> lane3 replaced with the new word, out_valid[3] stays 1, rr_ptr=4.
- Simultaneous drain and load on lane 0 every cycle for 4 cycles (data 1,2,3,4) -> out_data lane0 shows 1,2,3,4 in consecutive cycles with out_valid[0] continuously 1.
- Fill lanes 0,4,7 and then assert reset for 1 cycle with in_valid=1 -> out_valid=0, rr_ptr=0, in_ready=0 during reset, and no word captured.
- rr_ptr=6 with rr_mode switched to 0, two accepts to in_sel=1, then rr_mode=1 -> rr_ptr still 6 and the next accept goes to lane 6.
